// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: AXI field widths, index-width helper,
// AW payload layout and arbiter FSM states.
package axi_ic_pkg;

  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_ID_W   = 4;

  // Width needed to index n items; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_LEN_W-1:0]  len;
  } aw_payload_t;

  typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;

endpackage

// File: rtl/axi_aw_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping N-1 -> 0. Shared by the AW and AR arbiters.
module rr_pick
  import axi_ic_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = idx_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt_onehot,
  output logic [W-1:0] o_gnt_idx,
  output logic         o_any
);

  localparam logic [W:0] NV = (W+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [W-1:0]   w_off;
  logic [W:0]     w_sum;

  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> i_ptr);

  // Lowest set bit of the rotated vector is the offset from ptr.
  always_comb begin
    o_any = 1'b0;
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any = 1'b1;
        w_off = W'(k);
      end
    end
  end

  assign w_sum     = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_gnt_idx = (w_sum >= NV) ? W'(w_sum - NV) : W'(w_sum);

  always_comb begin
    o_gnt_onehot = '0;
    for (int i = 0; i < N; i++) begin
      o_gnt_onehot[i] = o_any && (o_gnt_idx == W'(i));
    end
  end

endmodule

// File: rtl/axi_aw_arbiter.sv
// N-master to 1-slave round-robin AW arbiter; registers the granted payload
// and pushes {master, awlen} to the W-routing order FIFO on slave handshake.
module axi_aw_arbiter
  import axi_ic_pkg::*;
#(
  parameter  int unsigned NM  = 4,
  parameter  int unsigned ADW = 32,
  parameter  int unsigned IDW = 4,
  localparam int unsigned MIW = idx_w(NM)
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic [NM-1:0]            i_awvalid,
  input  logic [NM*ADW-1:0]        i_awaddr,
  input  logic [NM*IDW-1:0]        i_awid,
  input  logic [NM*AXI_LEN_W-1:0]  i_awlen,
  output logic [NM-1:0]            o_awready,
  output logic                     o_awvalid,
  output logic [ADW-1:0]           o_awaddr,
  output logic [IDW-1:0]           o_awid,
  output logic [AXI_LEN_W-1:0]     o_awlen,
  input  logic                     i_awready,
  output logic                     o_push,
  output logic [MIW+AXI_LEN_W-1:0] o_push_data,
  input  logic                     i_fifo_full
);

  arb_state_t           r_state;
  logic [MIW-1:0]       r_ptr;
  logic [MIW-1:0]       r_idx;

  logic [NM-1:0]        w_gnt_oh;
  logic [MIW-1:0]       w_gnt_idx;
  logic                 w_any;
  logic                 w_grant;
  logic [ADW-1:0]       w_sel_addr;
  logic [IDW-1:0]       w_sel_id;
  logic [AXI_LEN_W-1:0] w_sel_len;

  rr_pick #(.N(NM)) u_pick (
    .i_req        (i_awvalid),
    .i_ptr        (r_ptr),
    .o_gnt_onehot (w_gnt_oh),
    .o_gnt_idx    (w_gnt_idx),
    .o_any        (w_any)
  );

  // FIFO space is only checked here; nothing else pushes before our own push.
  assign w_grant   = i_resetn && (r_state == ST_IDLE) && w_any && !i_fifo_full;
  assign o_awready = w_grant ? w_gnt_oh : '0;

  assign o_push      = o_awvalid && i_awready;
  assign o_push_data = o_push ? {r_idx, o_awlen} : '0;

  always_comb begin
    w_sel_addr = '0;
    w_sel_id   = '0;
    w_sel_len  = '0;
    for (int m = 0; m < NM; m++) begin
      if (w_gnt_idx == MIW'(m)) begin
        w_sel_addr = i_awaddr[m*ADW +: ADW];
        w_sel_id   = i_awid[m*IDW +: IDW];
        w_sel_len  = i_awlen[m*AXI_LEN_W +: AXI_LEN_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      o_awvalid <= 1'b0;
      o_awaddr  <= '0;
      o_awid    <= '0;
      o_awlen   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state   <= ST_BUSY;
            r_idx     <= w_gnt_idx;
            r_ptr     <= (w_gnt_idx == MIW'(NM - 1)) ? '0 : MIW'(w_gnt_idx + MIW'(1));
            o_awvalid <= 1'b1;
            o_awaddr  <= w_sel_addr;
            o_awid    <= w_sel_id;
            o_awlen   <= w_sel_len;
          end
        end
        ST_BUSY: begin
          if (i_awready) begin
            r_state   <= ST_IDLE;
            o_awvalid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// Self-checking bench for axi_aw_arbiter: NM=4 instance against a
// transaction-level model, plus an NM=3 instance for wrap and reset cases.
module tb_axi_aw_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // NM=4 instance
  logic [3:0]   a_awvalid;
  logic [127:0] a_awaddr;
  logic [15:0]  a_awid;
  logic [31:0]  a_awlen;
  logic         a_sready, a_full;
  logic [3:0]   a_o_awready;
  logic         a_o_awvalid, a_o_push;
  logic [31:0]  a_o_awaddr;
  logic [3:0]   a_o_awid;
  logic [7:0]   a_o_awlen;
  logic [9:0]   a_o_push_data;

  // NM=3 instance
  logic [2:0]   b_awvalid;
  logic [95:0]  b_awaddr;
  logic [11:0]  b_awid;
  logic [23:0]  b_awlen;
  logic         b_sready, b_full;
  logic [2:0]   b_o_awready;
  logic         b_o_awvalid, b_o_push;
  logic [31:0]  b_o_awaddr;
  logic [3:0]   b_o_awid;
  logic [7:0]   b_o_awlen;
  logic [9:0]   b_o_push_data;

  axi_aw_arbiter #(.NM(4), .ADW(32), .IDW(4)) dut4 (
    .i_clk(clk), .i_resetn(resetn),
    .i_awvalid(a_awvalid), .i_awaddr(a_awaddr), .i_awid(a_awid), .i_awlen(a_awlen),
    .o_awready(a_o_awready), .o_awvalid(a_o_awvalid), .o_awaddr(a_o_awaddr),
    .o_awid(a_o_awid), .o_awlen(a_o_awlen), .i_awready(a_sready),
    .o_push(a_o_push), .o_push_data(a_o_push_data), .i_fifo_full(a_full)
  );

  axi_aw_arbiter #(.NM(3), .ADW(32), .IDW(4)) dut3 (
    .i_clk(clk), .i_resetn(resetn),
    .i_awvalid(b_awvalid), .i_awaddr(b_awaddr), .i_awid(b_awid), .i_awlen(b_awlen),
    .o_awready(b_o_awready), .o_awvalid(b_o_awvalid), .o_awaddr(b_o_awaddr),
    .o_awid(b_o_awid), .o_awlen(b_o_awlen), .i_awready(b_sready),
    .o_push(b_o_push), .o_push_data(b_o_push_data), .i_fifo_full(b_full)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model of the NM=4 arbiter
  bit          m_busy;
  int          m_g, m_ptr, cyc, obs_push;
  logic [31:0] m_addr;
  logic [3:0]  m_id;
  logic [7:0]  m_len;
  int          grants[$];
  int          gcyc[$];

  function automatic int pick(input logic [3:0] req, input int ptr, input int nm);
    for (int k = 0; k < nm; k++)
      if (req[(ptr + k) % nm]) return (ptr + k) % nm;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_ptr = 0; m_addr = '0; m_id = '0; m_len = '0;
    grants.delete(); gcyc.delete(); obs_push = 0;
  endtask

  task automatic zero_inputs();
    a_awvalid = '0; a_awaddr = '0; a_awid = '0; a_awlen = '0; a_sready = 0; a_full = 0;
    b_awvalid = '0; b_awaddr = '0; b_awid = '0; b_awlen = '0; b_sready = 0; b_full = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    zero_inputs();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // One cycle of dut4: check against model at negedge+1, advance, drop granted request.
  task automatic step();
    logic [3:0] ea;
    logic [9:0] epd;
    bit eg;
    int g;
    #1;
    eg = !m_busy && (a_awvalid != 0) && !a_full;
    g  = pick(a_awvalid, m_ptr, 4);
    ea = eg ? 4'(1 << g) : 4'b0;
    n_tests++;
    if (a_o_awready !== ea) begin
      n_fail++; $display("FAIL awready cyc=%0d got=%b exp=%b", cyc, a_o_awready, ea);
    end
    n_tests++;
    if (a_o_awvalid !== m_busy) begin
      n_fail++; $display("FAIL awvalid cyc=%0d got=%b exp=%b", cyc, a_o_awvalid, m_busy);
    end
    n_tests++;
    if (a_o_push !== (m_busy && a_sready)) begin
      n_fail++; $display("FAIL push cyc=%0d got=%b exp=%b", cyc, a_o_push, m_busy && a_sready);
    end
    if (m_busy) begin
      epd = {2'(m_g), m_len};
      n_tests++;
      if ({a_o_awaddr, a_o_awid, a_o_awlen} !== {m_addr, m_id, m_len}) begin
        n_fail++; $display("FAIL payload cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc,
                           a_o_awaddr, a_o_awid, a_o_awlen, m_addr, m_id, m_len);
      end
      if (a_sready) begin
        n_tests++;
        if (a_o_push_data !== epd) begin
          n_fail++; $display("FAIL push_data cyc=%0d got=%h exp=%h", cyc, a_o_push_data, epd);
        end
      end
    end
    if (a_o_push === 1'b1) obs_push++;
    @(posedge clk);
    if (eg) begin
      m_busy = 1; m_g = g;
      m_addr = a_awaddr[g*32 +: 32]; m_id = a_awid[g*4 +: 4]; m_len = a_awlen[g*8 +: 8];
      m_ptr = (g + 1) % 4;
      grants.push_back(g); gcyc.push_back(cyc);
    end else if (m_busy && a_sready) begin
      m_busy = 0;
    end
    cyc++;
    @(negedge clk);
    if (eg) a_awvalid[g] = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int r = 0; r < 3; r++) begin
      a_awvalid = 4'($urandom); a_awaddr = {$urandom, $urandom, $urandom, $urandom};
      a_awid = 16'($urandom); a_awlen = $urandom; a_sready = 1'($urandom); a_full = 1'($urandom);
      b_awvalid = 3'($urandom); b_awaddr = {$urandom, $urandom, $urandom};
      b_awid = 12'($urandom); b_awlen = 24'($urandom); b_sready = 1'($urandom); b_full = 1'($urandom);
      #3;
      n_tests++;
      if ({a_o_awready, a_o_awvalid, a_o_awaddr, a_o_awid, a_o_awlen, a_o_push, a_o_push_data} !== '0) begin
        n_fail++; $display("FAIL reset4 got rdy=%b v=%b a=%h id=%h l=%h p=%b pd=%h exp all 0",
                           a_o_awready, a_o_awvalid, a_o_awaddr, a_o_awid, a_o_awlen, a_o_push, a_o_push_data);
      end
      n_tests++;
      if ({b_o_awready, b_o_awvalid, b_o_awaddr, b_o_awid, b_o_awlen, b_o_push, b_o_push_data} !== '0) begin
        n_fail++; $display("FAIL reset3 got rdy=%b v=%b p=%b pd=%h exp all 0",
                           b_o_awready, b_o_awvalid, b_o_push, b_o_push_data);
      end
    end
    @(negedge clk);
    zero_inputs();
    resetn = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      a_sready = 1'($urandom);
      step();
    end
    n_tests++;
    if (obs_push != 0 || grants.size() != 0) begin
      n_fail++; $display("FAIL idle_activity got pushes=%0d grants=%0d exp 0/0", obs_push, grants.size());
    end
  endtask

  task automatic test_single();
    a_awvalid = 4'b0100;
    a_awaddr[2*32 +: 32] = 32'h1000; a_awid[2*4 +: 4] = 4'd3; a_awlen[2*8 +: 8] = 8'd7;
    a_sready = 1'b1;
    #1;
    n_tests++;
    if (a_o_awready !== 4'b0100) begin
      n_fail++; $display("FAIL single_awready got=%b exp=0100", a_o_awready);
    end
    step();
    #1;
    n_tests++;
    if ({a_o_awvalid, a_o_awaddr, a_o_awid, a_o_awlen, a_o_push, a_o_push_data} !==
        {1'b1, 32'h1000, 4'd3, 8'd7, 1'b1, 2'd2, 8'd7}) begin
      n_fail++; $display("FAIL single_out got v=%b a=%h id=%h l=%h p=%b pd=%h exp 1/1000/3/07/1/207",
                         a_o_awvalid, a_o_awaddr, a_o_awid, a_o_awlen, a_o_push, a_o_push_data);
    end
    step();
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    a_sready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int m = 0; m < 4; m++) begin
        if (!a_awvalid[m]) begin
          a_awvalid[m] = 1'b1;
          a_awaddr[m*32 +: 32] = $urandom; a_awid[m*4 +: 4] = 4'($urandom); a_awlen[m*8 +: 8] = 8'($urandom);
        end
      end
      step();
    end
    n_tests++;
    if (grants.size() < 6) begin
      n_fail++; $display("FAIL rr_count got=%0d exp>=6", grants.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (grants[i] != i % 4) begin
          n_fail++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, grants[i], i % 4);
        end
        if (i > 0) begin
          n_tests++;
          if (gcyc[i] - gcyc[i-1] != 2) begin
            n_fail++; $display("FAIL rr_spacing idx=%0d got=%0d exp=2", i, gcyc[i] - gcyc[i-1]);
          end
        end
      end
    end
    a_awvalid = '0;
    step(); step();
  endtask

  task automatic test_backpressure();
    logic [43:0] held;
    int p0;
    a_sready = 1'b0;
    a_awvalid = 4'b0001;
    a_awaddr[31:0] = $urandom; a_awid[3:0] = 4'($urandom); a_awlen[7:0] = 8'($urandom);
    step();
    #1;
    held = {a_o_awaddr, a_o_awid, a_o_awlen};
    p0 = obs_push;
    a_awvalid = 4'b1110;
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if ({a_o_awaddr, a_o_awid, a_o_awlen} !== held || a_o_awready !== 4'b0) begin
        n_fail++; $display("FAIL bp_hold got=%h rdy=%b exp=%h rdy=0000",
                           {a_o_awaddr, a_o_awid, a_o_awlen}, a_o_awready, held);
      end
    end
    a_sready = 1'b1;
    step();
    n_tests++;
    if (obs_push - p0 != 1) begin
      n_fail++; $display("FAIL bp_push_count got=%0d exp=1", obs_push - p0);
    end
    a_awvalid = '0;
    step(); step(); step();
  endtask

  task automatic test_fifo_full();
    a_full = 1'b1;
    a_sready = 1'b1;
    a_awvalid = 4'b0010;
    a_awaddr[63:32] = 32'hCAFE_0000; a_awid[7:4] = 4'd9; a_awlen[15:8] = 8'd15;
    for (int c = 0; c < 6; c++) step();
    a_full = 1'b0;
    #1;
    n_tests++;
    if (a_o_awready !== 4'b0010) begin
      n_fail++; $display("FAIL full_release got=%b exp=0010", a_o_awready);
    end
    step();
    a_full = 1'b1;
    step();
    a_full = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 4; m++) begin
        if (!a_awvalid[m] && $urandom_range(0, 2) == 0) begin
          a_awvalid[m] = 1'b1;
          a_awaddr[m*32 +: 32] = $urandom; a_awid[m*4 +: 4] = 4'($urandom); a_awlen[m*8 +: 8] = 8'($urandom);
        end
      end
      a_sready = 1'($urandom);
      a_full   = ($urandom_range(0, 3) == 0);
      step();
    end
    a_awvalid = '0; a_full = 1'b0; a_sready = 1'b1;
    step(); step();
  endtask

  task automatic test_nonpow2();
    do_reset();
    b_sready = 1'b1;
    b_awvalid = 3'b100; b_awlen[23:16] = 8'h22; b_awlen[7:0] = 8'h10;
    #1;
    n_tests++;
    if (b_o_awready !== 3'b100) begin
      n_fail++; $display("FAIL np2_first got=%b exp=100", b_o_awready);
    end
    @(posedge clk); @(negedge clk);
    b_awvalid = 3'b101;
    #1;
    n_tests++;
    if ({b_o_awvalid, b_o_push, b_o_push_data, b_o_awready} !== {1'b1, 1'b1, 2'd2, 8'h22, 3'b000}) begin
      n_fail++; $display("FAIL np2_push2 got v=%b p=%b pd=%h rdy=%b exp 1/1/222/000",
                         b_o_awvalid, b_o_push, b_o_push_data, b_o_awready);
    end
    @(posedge clk); @(negedge clk);
    #1;
    n_tests++;
    if (b_o_awready !== 3'b001) begin
      n_fail++; $display("FAIL np2_wrap got=%b exp=001", b_o_awready);
    end
    @(posedge clk); @(negedge clk);
    b_awvalid = 3'b100;
    #1;
    n_tests++;
    if (b_o_push_data !== {2'd0, 8'h10}) begin
      n_fail++; $display("FAIL np2_push0 got=%h exp=010", b_o_push_data);
    end
    @(posedge clk); @(negedge clk);
    #1;
    n_tests++;
    if (b_o_awready !== 3'b100) begin
      n_fail++; $display("FAIL np2_next got=%b exp=100", b_o_awready);
    end
    b_sready = 1'b0;
    @(posedge clk); @(negedge clk);
    b_awvalid = 3'b000;
    b_sready = 1'b1;
    #1;
    n_tests++;
    if (b_o_awvalid !== 1'b1) begin
      n_fail++; $display("FAIL np2_busy got=%b exp=1", b_o_awvalid);
    end
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({b_o_awvalid, b_o_push, b_o_push_data} !== '0) begin
      n_fail++; $display("FAIL np2_reset_busy got v=%b p=%b pd=%h exp 0/0/000",
                         b_o_awvalid, b_o_push, b_o_push_data);
    end
    @(negedge clk);
    zero_inputs();
    resetn = 1'b1;
    model_reset();
    step();
  endtask

  initial begin
    cyc = 0;
    zero_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_random();
    test_nonpow2();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
